// File: rtl/vend_pkg.sv
// Shared state type and default widths for the vending controller slice.
package vend_pkg;

    localparam int unsigned CODE_W_DEF     = 2;
    localparam int unsigned COUNT_W_DEF    = 3;
    localparam int unsigned MONEY_W_DEF    = 4;
    localparam int unsigned STOCK_INIT_DEF = 7;
    localparam int unsigned NUM_PROD       = 2 ** CODE_W_DEF;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        DISPENSE,
        REJECT,
        CHANGE
    } state_t;

endpackage

// File: rtl/vend_stock_table.sv
// Per-product stock counters: restock overwrite, decrement on dispense, read of the addressed entry.
module vend_stock_table
    import vend_pkg::*;
#(
    parameter int unsigned        CODE_W     = CODE_W_DEF,
    parameter int unsigned        COUNT_W    = COUNT_W_DEF,
    parameter int unsigned        N_ENTRY    = NUM_PROD,
    parameter logic [COUNT_W-1:0] STOCK_INIT = COUNT_W'(STOCK_INIT_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [CODE_W-1:0]  wr_code,
    input  logic [COUNT_W-1:0] wr_qty,
    input  logic               dec_en,
    input  logic [COUNT_W-1:0] dec_qty,
    input  logic [CODE_W-1:0]  rd_code,
    output logic [COUNT_W-1:0] rd_qty
);

    logic [COUNT_W-1:0] stock [N_ENTRY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_ENTRY; i++) begin
                stock[i] <= STOCK_INIT;
            end
        end else begin
            if (wr_en) begin
                stock[wr_code] <= wr_qty;
            end
            if (dec_en) begin
                stock[rd_code] <= stock[rd_code] - dec_qty;
            end
        end
    end

    assign rd_qty = stock[rd_code];

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: coin credit, selection latch, stock check, dispense/reject, change handshake.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned CODE_W     = CODE_W_DEF,
    parameter int unsigned COUNT_W    = COUNT_W_DEF,
    parameter int unsigned MONEY_W    = MONEY_W_DEF,
    parameter int unsigned STOCK_INIT = STOCK_INIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_valid,
    input  logic [MONEY_W-1:0] coin_value,
    input  logic               sel_valid,
    input  logic [CODE_W-1:0]  sel_code,
    input  logic [COUNT_W-1:0] sel_count,
    input  logic               cancel,
    input  logic               restock_valid,
    input  logic [CODE_W-1:0]  restock_code,
    input  logic [COUNT_W-1:0] restock_qty,
    input  logic               change_ack,
    output logic [CODE_W-1:0]  dp_code,
    output logic [COUNT_W-1:0] dp_count,
    output logic [MONEY_W-1:0] dp_money,
    input  logic               dp_possible,
    input  logic [MONEY_W-1:0] dp_remaining,
    output logic [MONEY_W-1:0] credit,
    output logic               coin_reject,
    output logic               vend,
    output logic [CODE_W-1:0]  vend_code,
    output logic [COUNT_W-1:0] vend_count,
    output logic               sel_error,
    output logic               change_valid,
    output logic [MONEY_W-1:0] change_amount,
    output logic               busy
);

    state_t             state, state_nx;
    logic [MONEY_W-1:0] credit_nx, change_nx;
    logic [CODE_W-1:0]  code_nx;
    logic [COUNT_W-1:0] count_nx;
    logic               reject_nx;
    logic               restock_en, dec_en;
    logic [COUNT_W-1:0] stock_rd;
    logic [MONEY_W:0]   coin_sum;
    logic               sel_ok;

    vend_stock_table #(
        .CODE_W    (CODE_W),
        .COUNT_W   (COUNT_W),
        .N_ENTRY   (2 ** CODE_W),
        .STOCK_INIT(COUNT_W'(STOCK_INIT))
    ) u_stock (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (restock_en),
        .wr_code(restock_code),
        .wr_qty (restock_qty),
        .dec_en (dec_en),
        .dec_qty(dp_count),
        .rd_code(dp_code),
        .rd_qty (stock_rd)
    );

    // Carry out of the widened sum flags a credit overflow.
    assign coin_sum = {1'b0, credit} + {1'b0, coin_value};
    assign sel_ok   = dp_possible && (dp_count != '0) && (stock_rd >= dp_count);

    always_comb begin
        state_nx   = state;
        credit_nx  = credit;
        change_nx  = change_amount;
        code_nx    = dp_code;
        count_nx   = dp_count;
        reject_nx  = 1'b0;
        restock_en = 1'b0;
        dec_en     = 1'b0;
        unique case (state)
            IDLE: begin
                restock_en = restock_valid;
                if (coin_valid) begin
                    credit_nx = coin_value;
                    state_nx  = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    reject_nx = coin_valid;
                    change_nx = credit;
                    state_nx  = CHANGE;
                end else if (sel_valid) begin
                    reject_nx = coin_valid;
                    code_nx   = sel_code;
                    count_nx  = sel_count;
                    state_nx  = CHECK;
                end else if (coin_valid) begin
                    if (coin_sum[MONEY_W]) begin
                        reject_nx = 1'b1;
                    end else begin
                        credit_nx = coin_sum[MONEY_W-1:0];
                    end
                end
            end
            CHECK: begin
                reject_nx = coin_valid;
                if (sel_ok) begin
                    change_nx = dp_remaining;
                    state_nx  = DISPENSE;
                end else begin
                    state_nx  = REJECT;
                end
            end
            DISPENSE: begin
                reject_nx = coin_valid;
                dec_en    = 1'b1;
                credit_nx = '0;
                state_nx  = CHANGE;
            end
            REJECT: begin
                reject_nx = coin_valid;
                state_nx  = COLLECT;
            end
            CHANGE: begin
                reject_nx = coin_valid;
                if ((change_amount == '0) || change_ack) begin
                    credit_nx = '0;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            credit        <= '0;
            change_amount <= '0;
            dp_code       <= '0;
            dp_count      <= '0;
            coin_reject   <= 1'b0;
        end else begin
            state         <= state_nx;
            credit        <= credit_nx;
            change_amount <= change_nx;
            dp_code       <= code_nx;
            dp_count      <= count_nx;
            coin_reject   <= reject_nx;
        end
    end

    assign dp_money     = credit;
    assign vend         = (state == DISPENSE);
    assign vend_code    = dp_code;
    assign vend_count   = dp_count;
    assign sel_error    = (state == REJECT);
    assign change_valid = (state == CHANGE) && (change_amount != '0);
    assign busy         = (state != IDLE) && (state != COLLECT);

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus random traffic against a timeline model.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_valid, sel_valid, cancel, restock_valid, change_ack;
    logic [3:0] coin_value;
    logic [1:0] sel_code, restock_code;
    logic [2:0] sel_count, restock_qty;
    logic [1:0] dp_code, vend_code;
    logic [2:0] dp_count, vend_count;
    logic [3:0] dp_money, dp_remaining, credit, change_amount;
    logic       dp_possible, coin_reject, vend, sel_error, change_valid, busy;
    logic [7:0] cost;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    // Datapath stub: each unit costs 3.
    assign cost         = 8'(dp_count) * 8'd3;
    assign dp_possible  = (8'(dp_money) >= cost);
    assign dp_remaining = dp_money - cost[3:0];

    vend_controller dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .sel_valid    (sel_valid),
        .sel_code     (sel_code),
        .sel_count    (sel_count),
        .cancel       (cancel),
        .restock_valid(restock_valid),
        .restock_code (restock_code),
        .restock_qty  (restock_qty),
        .change_ack   (change_ack),
        .dp_code      (dp_code),
        .dp_count     (dp_count),
        .dp_money     (dp_money),
        .dp_possible  (dp_possible),
        .dp_remaining (dp_remaining),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .vend         (vend),
        .vend_code    (vend_code),
        .vend_count   (vend_count),
        .sel_error    (sel_error),
        .change_valid (change_valid),
        .change_amount(change_amount),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Timeline model: plan holds the fixed-length busy cycles after a selection
    // (1 = evaluation cycle, 2 = dispense cycle, 3 = refusal cycle).
    int m_credit, m_code, m_count, m_chg;
    int m_stock [4];
    bit m_open, m_wait, m_rej;
    int plan [$];

    task automatic model_reset();
        m_credit = 0; m_code = 0; m_count = 0; m_chg = 0;
        m_open = 0; m_wait = 0; m_rej = 0;
        plan.delete();
        for (int i = 0; i < 4; i++) m_stock[i] = 7;
    endtask

    task automatic model_step();
        bit rej;
        int price;
        int act;
        rej = 0;
        if (plan.size() > 0) begin
            act = plan.pop_front();
            rej = coin_valid;
            if (act == 2) begin
                m_stock[m_code] = m_stock[m_code] - m_count;
                m_credit = 0;
                m_wait = 1;
            end
        end else if (m_wait) begin
            rej = coin_valid;
            if (m_chg == 0 || change_ack) begin
                m_wait = 0; m_open = 0; m_credit = 0;
            end
        end else if (!m_open) begin
            if (restock_valid) m_stock[restock_code] = int'(restock_qty);
            if (coin_valid) begin
                m_credit = int'(coin_value);
                m_open = 1;
            end
        end else if (cancel) begin
            rej = coin_valid;
            m_chg = m_credit;
            m_wait = 1;
        end else if (sel_valid) begin
            rej = coin_valid;
            m_code = int'(sel_code);
            m_count = int'(sel_count);
            price = 3 * m_count;
            if (m_count != 0 && m_credit >= price && m_stock[m_code] >= m_count) begin
                m_chg = m_credit - price;
                plan = '{1, 2};
            end else begin
                plan = '{1, 3};
            end
        end else if (coin_valid) begin
            if (m_credit + int'(coin_value) > 15) rej = 1;
            else m_credit = m_credit + int'(coin_value);
        end
        m_rej = rej;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            logic e_vend, e_err, e_busy, e_cv;
            e_busy = (plan.size() > 0) || m_wait;
            e_vend = (plan.size() > 0) ? (plan[0] == 2) : 1'b0;
            e_err  = (plan.size() > 0) ? (plan[0] == 3) : 1'b0;
            e_cv   = m_wait && (m_chg != 0);
            chk("credit", 32'(credit), m_credit);
            chk("dp_money", 32'(dp_money), m_credit);
            chk("dp_code", 32'(dp_code), m_code);
            chk("dp_count", 32'(dp_count), m_count);
            chk("busy", 32'(busy), 32'(e_busy));
            chk("vend", 32'(vend), 32'(e_vend));
            chk("sel_error", 32'(sel_error), 32'(e_err));
            chk("coin_reject", 32'(coin_reject), 32'(m_rej));
            chk("change_valid", 32'(change_valid), 32'(e_cv));
            if (e_cv) chk("change_amount", 32'(change_amount), m_chg);
            if (e_vend) begin
                chk("vend_code", 32'(vend_code), m_code);
                chk("vend_count", 32'(vend_count), m_count);
            end
        end
    end

    task automatic clr();
        coin_valid = 0; coin_value = '0; sel_valid = 0; sel_code = '0; sel_count = '0;
        cancel = 0; restock_valid = 0; restock_code = '0; restock_qty = '0; change_ack = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic coin(input int v);
        clr(); coin_valid = 1; coin_value = 4'(v); tick(); clr();
    endtask

    task automatic sel(input int c, input int n);
        clr(); sel_valid = 1; sel_code = 2'(c); sel_count = 3'(n); tick(); clr();
    endtask

    task automatic do_cancel();
        clr(); cancel = 1; tick(); clr();
    endtask

    task automatic ack();
        clr(); change_ack = 1; tick(); clr();
    endtask

    task automatic restock(input int c, input int q);
        clr(); restock_valid = 1; restock_code = 2'(c); restock_qty = 3'(q); tick(); clr();
    endtask

    task automatic chk_stock(input string nm, input int v);
        chk({nm, "0"}, 32'(dut.u_stock.stock[0]), v);
        chk({nm, "1"}, 32'(dut.u_stock.stock[1]), v);
        chk({nm, "2"}, 32'(dut.u_stock.stock[2]), v);
        chk({nm, "3"}, 32'(dut.u_stock.stock[3]), v);
    endtask

    initial begin
        clr();
        model_reset();
        #1 rst = 1;
        tick();
        tick();
        chk("rst_credit", 32'(credit), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_change_valid", 32'(change_valid), 0);
        chk_stock("rst_stock", 7);
        rst = 0;
        chk_en = 1;

        // Buy one unit of product 2 with 10 credit: 7 change.
        coin(5); coin(5);
        chk("s1_credit", 32'(credit), 10);
        sel(2, 1);
        chk("s1_busy_check", 32'(busy), 1);
        tick();
        chk("s1_vend", 32'(vend), 1);
        chk("s1_vend_code", 32'(vend_code), 2);
        chk("s1_vend_count", 32'(vend_count), 1);
        tick();
        chk("s1_change_valid", 32'(change_valid), 1);
        chk("s1_change_amount", 32'(change_amount), 7);
        ack();
        chk("s1_idle", 32'(busy), 0);
        chk("s1_credit0", 32'(credit), 0);
        chk("s1_stock2", 32'(dut.u_stock.stock[2]), 6);
        chk("s1_model_stock2", m_stock[2], 6);

        // Overflowing coin is refused; cancel refunds credit.
        coin(10); coin(8);
        chk("s2_coin_reject", 32'(coin_reject), 1);
        chk("s2_credit", 32'(credit), 10);
        do_cancel();
        chk("s2_change_valid", 32'(change_valid), 1);
        chk("s2_change_amount", 32'(change_amount), 10);
        ack();
        chk("s2_idle", 32'(busy), 0);

        // Insufficient credit, then exact payment with no change phase.
        coin(4); sel(0, 2); tick();
        chk("s3_sel_error", 32'(sel_error), 1);
        tick();
        chk("s3_collect", 32'(busy), 0);
        chk("s3_credit", 32'(credit), 4);
        coin(2); sel(0, 2); tick();
        chk("s3_vend", 32'(vend), 1);
        tick();
        chk("s3_no_change", 32'(change_valid), 0);
        tick();
        chk("s3_idle", 32'(busy), 0);
        chk("s3_model_stock0", m_stock[0], 5);

        // Stock shortfall; coin colliding with selection is refused.
        restock(0, 1);
        chk("s4_stock0", 32'(dut.u_stock.stock[0]), 1);
        coin(15);
        chk("s4_credit", 32'(credit), 15);
        clr(); sel_valid = 1; sel_code = 2'd0; sel_count = 3'd2; coin_valid = 1; coin_value = 4'd1;
        tick(); clr();
        chk("s4_coin_reject", 32'(coin_reject), 1);
        chk("s4_busy_check", 32'(busy), 1);
        tick();
        chk("s4_sel_error", 32'(sel_error), 1);
        chk("s4_credit_kept", 32'(credit), 15);
        tick();
        do_cancel();
        chk("s4_change_amount", 32'(change_amount), 15);
        ack();

        // Asynchronous reset while change is on offer.
        coin(9); do_cancel();
        chk("s5_change_valid", 32'(change_valid), 1);
        rst = 1;
        #1;
        chk("s5_rst_change_valid", 32'(change_valid), 0);
        chk("s5_rst_change_amount", 32'(change_amount), 0);
        chk("s5_rst_credit", 32'(credit), 0);
        chk("s5_rst_busy", 32'(busy), 0);
        chk("s5_rst_dp_code", 32'(dp_code), 0);
        chk_stock("s5_rst_stock", 7);
        tick();
        rst = 0;

        for (int n = 0; n < 3000; n++) begin
            clr();
            coin_valid    = ($urandom_range(0, 3) == 0);
            coin_value    = 4'($urandom_range(0, 9));
            sel_valid     = ($urandom_range(0, 5) == 0);
            sel_code      = 2'($urandom_range(0, 3));
            sel_count     = 3'($urandom_range(0, 6));
            cancel        = ($urandom_range(0, 19) == 0);
            restock_valid = ($urandom_range(0, 9) == 0);
            restock_code  = 2'($urandom_range(0, 3));
            restock_qty   = 3'($urandom_range(0, 7));
            change_ack    = ($urandom_range(0, 2) == 0);
            tick();
        end
        clr();
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
